// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
// Receives a framed byte stream (4-byte big-endian word count N, N big-endian
// data words, 1 XOR checksum byte) over a valid/ready handshake. Each assembled
// word is written to instruction memory at consecutive word addresses starting
// at ADDR_BASE. The CPU is held in reset until the image has been loaded and
// its checksum has verified.
module imem_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_ld_i,
    input  logic        byte_valid_ld_i,
    input  logic [7:0]  byte_data_ld_i,
    output logic        byte_ready_ld_o,
    output logic        wr_en_imem_ld_o,
    output logic [31:0] addr_imem_ld_o,
    output logic [31:0] wr_instr_imem_ld_o,
    output logic        cpu_reset_ld_o,
    output logic        busy_ld_o,
    output logic        done_ld_o,
    output logic        err_ld_o,
    output logic [1:0]  err_code_ld_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_LENGTH = 2'd1;
    localparam logic [1:0] ERR_CSUM   = 2'd2;

    state_t      state;
    logic [1:0]  byte_cnt;   // byte position within the current 4-byte group
    logic [31:0] shift_reg;  // big-endian assembly register
    logic [7:0]  csum;       // running XOR of header and data bytes
    logic [31:0] word_cnt;   // N, latched from the header
    logic [31:0] word_idx;   // index of the next word to be written

    logic        accept;
    logic [31:0] assembled;
    logic [31:0] next_idx;

    assign accept    = byte_valid_ld_i & byte_ready_ld_o;
    assign assembled = {shift_reg[23:0], byte_data_ld_i};
    assign next_idx  = word_idx + 32'd1;

    // Ready depends on state only, so a source may wait on it without a loop.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal; no latch.
        byte_ready_ld_o = 1'b0;
        case (state)
            S_HDR, S_DATA, S_CSUM: byte_ready_ld_o = 1'b1;
            default:               byte_ready_ld_o = 1'b0;
        endcase
    end

    // Session FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments for all state so every register
            // samples pre-edge values, independent of statement order.
            state              <= S_IDLE;
            byte_cnt           <= 2'd0;
            shift_reg          <= 32'd0;
            csum               <= 8'd0;
            word_cnt           <= 32'd0;
            word_idx           <= 32'd0;
            wr_en_imem_ld_o    <= 1'b0;
            addr_imem_ld_o     <= 32'd0;
            wr_instr_imem_ld_o <= 32'd0;
            cpu_reset_ld_o     <= 1'b1;
            busy_ld_o          <= 1'b0;
            done_ld_o          <= 1'b0;
            err_ld_o           <= 1'b0;
            err_code_ld_o      <= ERR_NONE;
        end else begin
            case (state)
                // Idle or finished: a start pulse opens a fresh session and
                // puts the CPU back into reset.
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_ld_i) begin
                        state          <= S_HDR;
                        busy_ld_o      <= 1'b1;
                        byte_cnt       <= 2'd0;
                        csum           <= 8'd0;
                        word_idx       <= 32'd0;
                        cpu_reset_ld_o <= 1'b1;
                        done_ld_o      <= 1'b0;
                        err_ld_o       <= 1'b0;
                        err_code_ld_o  <= ERR_NONE;
                    end
                end

                S_HDR: begin
                    if (accept) begin
                        shift_reg <= assembled;
                        csum      <= csum ^ byte_data_ld_i;
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            word_cnt <= assembled;
                            word_idx <= 32'd0;
                            if (assembled > MAX_WORDS_W) begin
                                state         <= S_ERR;
                                err_ld_o      <= 1'b1;
                                err_code_ld_o <= ERR_LENGTH;
                                busy_ld_o     <= 1'b0;
                            end else if (assembled == 32'd0) begin
                                state <= S_CSUM;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end

                // The 4th byte of a word launches the one-cycle write strobe.
                S_DATA: begin
                    if (accept) begin
                        shift_reg <= assembled;
                        csum      <= csum ^ byte_data_ld_i;
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state              <= S_WRITE;
                            wr_en_imem_ld_o    <= 1'b1;
                            addr_imem_ld_o     <= ADDR_BASE + {word_idx[29:0], 2'b00};
                            wr_instr_imem_ld_o <= assembled;
                        end
                    end
                end

                // Strobe drops after one cycle; address and data hold.
                S_WRITE: begin
                    wr_en_imem_ld_o <= 1'b0;
                    word_idx        <= next_idx;
                    if (next_idx == word_cnt) begin
                        state <= S_CSUM;
                    end else begin
                        state <= S_DATA;
                    end
                end

                S_CSUM: begin
                    if (accept) begin
                        busy_ld_o <= 1'b0;
                        if (byte_data_ld_i == csum) begin
                            state          <= S_DONE;
                            done_ld_o      <= 1'b1;
                            cpu_reset_ld_o <= 1'b0;
                        end else begin
                            state         <= S_ERR;
                            err_ld_o      <= 1'b1;
                            err_code_ld_o <= ERR_CSUM;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. Two instances share all inputs: dut0 uses
// the default ADDR_BASE (0x0), dut1 uses ADDR_BASE = 0x400. Write strobes are
// captured on the falling edge into per-instance queues.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        valid;
    logic [7:0]  bdata;

    logic        ready0, wr_en0, cpu_reset0, busy0, done0, err0;
    logic [31:0] addr0, instr0;
    logic [1:0]  code0;

    logic        ready1, wr_en1, cpu_reset1, busy1, done1, err1;
    logic [31:0] addr1, instr1;
    logic [1:0]  code1;

    int total = 0;
    int bad   = 0;

    logic [63:0] wq0[$];
    logic [63:0] wq1[$];
    logic [7:0]  frame[$];

    imem_loader dut0 (
        .clk                (clk),
        .reset              (reset),
        .start_ld_i         (start),
        .byte_valid_ld_i    (valid),
        .byte_data_ld_i     (bdata),
        .byte_ready_ld_o    (ready0),
        .wr_en_imem_ld_o    (wr_en0),
        .addr_imem_ld_o     (addr0),
        .wr_instr_imem_ld_o (instr0),
        .cpu_reset_ld_o     (cpu_reset0),
        .busy_ld_o          (busy0),
        .done_ld_o          (done0),
        .err_ld_o           (err0),
        .err_code_ld_o      (code0)
    );

    imem_loader #(.ADDR_BASE(32'h0000_0400)) dut1 (
        .clk                (clk),
        .reset              (reset),
        .start_ld_i         (start),
        .byte_valid_ld_i    (valid),
        .byte_data_ld_i     (bdata),
        .byte_ready_ld_o    (ready1),
        .wr_en_imem_ld_o    (wr_en1),
        .addr_imem_ld_o     (addr1),
        .wr_instr_imem_ld_o (instr1),
        .cpu_reset_ld_o     (cpu_reset1),
        .busy_ld_o          (busy1),
        .done_ld_o          (done1),
        .err_ld_o           (err1),
        .err_code_ld_o      (code1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture write strobes away from the active edge.
    always @(negedge clk) begin
        if (wr_en0 === 1'b1) wq0.push_back({addr0, instr0});
        if (wr_en1 === 1'b1) wq1.push_back({addr1, instr1});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge with valid low.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        valid = 1'b1;
        bdata = b;
        while (ready0 !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait", {63'd0, ready0}, 64'd1);
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Send the first nbytes of frame (all when nbytes < 0), idling gap cycles between bytes.
    task automatic send_frame(input int gap, input int nbytes);
        int n = (nbytes < 0) ? frame.size() : nbytes;
        for (int i = 0; i < n; i++) begin
            send_byte(frame[i]);
            if (gap > 0 && i != n - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"},  {63'd0, ready0},     64'd0);
        chk({tag, "_wr_en"},  {63'd0, wr_en0},     64'd0);
        chk({tag, "_addr"},   {32'd0, addr0},      64'd0);
        chk({tag, "_instr"},  {32'd0, instr0},     64'd0);
        chk({tag, "_cpurst"}, {63'd0, cpu_reset0}, 64'd1);
        chk({tag, "_busy"},   {63'd0, busy0},      64'd0);
        chk({tag, "_done"},   {63'd0, done0},      64'd0);
        chk({tag, "_err"},    {63'd0, err0},       64'd0);
        chk({tag, "_code"},   {62'd0, code0},      64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        valid = 1'b0;
        bdata = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("idle");

        // Bytes offered in IDLE are not taken.
        valid = 1'b1;
        bdata = 8'hAA;
        @(negedge clk);
        chk("idle_no_ready", {63'd0, ready0}, 64'd0);
        valid = 1'b0;

        // Basic load. XOR of the 12 bytes is 0x57.
        wq0.delete(); wq1.delete();
        pulse_start();
        chk("basic_busy",  {63'd0, busy0},  64'd1);
        chk("basic_ready", {63'd0, ready0}, 64'd1);
        frame = '{8'h00, 8'h00, 8'h00, 8'h02,
                  8'h20, 8'h08, 8'h00, 8'h05,
                  8'h01, 8'h09, 8'h50, 8'h20, 8'h57};
        send_frame(0, -1);
        @(negedge clk);
        chk("basic_nwr",    64'(wq0.size()), 64'd2);
        chk("basic_wr0",    (wq0.size() > 0) ? wq0[0] : 64'hx, 64'h00000000_20080005);
        chk("basic_wr1",    (wq0.size() > 1) ? wq0[1] : 64'hx, 64'h00000004_01095020);
        chk("basic_b1_wr1", (wq1.size() > 1) ? wq1[1] : 64'hx, 64'h00000404_01095020);
        chk("basic_done",   {63'd0, done0},      64'd1);
        chk("basic_cpurst", {63'd0, cpu_reset0}, 64'd0);
        chk("basic_err",    {63'd0, err0},       64'd0);
        chk("basic_busy0",  {63'd0, busy0},      64'd0);
        chk("basic_hold",   {32'd0, addr0},      64'h4);

        // Empty image, started from DONE.
        wq0.delete(); wq1.delete();
        pulse_start();
        chk("empty_cpurst_rise", {63'd0, cpu_reset0}, 64'd1);
        chk("empty_done_clr",    {63'd0, done0},      64'd0);
        frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(0, -1);
        @(negedge clk);
        chk("empty_nwr",    64'(wq0.size()), 64'd0);
        chk("empty_done",   {63'd0, done0},      64'd1);
        chk("empty_cpurst", {63'd0, cpu_reset0}, 64'd0);

        // Oversize header: N = 1025.
        wq0.delete(); wq1.delete();
        pulse_start();
        frame = '{8'h00, 8'h00, 8'h04, 8'h01};
        send_frame(0, -1);
        valid = 1'b1;
        bdata = 8'h11;
        repeat (3) @(negedge clk);
        chk("over_ready", {63'd0, ready0}, 64'd0);
        valid = 1'b0;
        chk("over_err",    {63'd0, err0},       64'd1);
        chk("over_code",   {62'd0, code0},      64'd1);
        chk("over_cpurst", {63'd0, cpu_reset0}, 64'd1);
        chk("over_busy",   {63'd0, busy0},      64'd0);
        chk("over_nwr",    64'(wq0.size()), 64'd0);

        // Bad checksum, started from ERR.
        wq0.delete(); wq1.delete();
        pulse_start();
        chk("badck_err_clr",  {63'd0, err0},  64'd0);
        chk("badck_code_clr", {62'd0, code0}, 64'd0);
        frame = '{8'h00, 8'h00, 8'h00, 8'h02,
                  8'h20, 8'h08, 8'h00, 8'h05,
                  8'h01, 8'h09, 8'h50, 8'h20, 8'h5E};
        send_frame(0, -1);
        @(negedge clk);
        chk("badck_nwr",    64'(wq0.size()), 64'd2);
        chk("badck_wr1",    (wq0.size() > 1) ? wq0[1] : 64'hx, 64'h00000004_01095020);
        chk("badck_err",    {63'd0, err0},       64'd1);
        chk("badck_code",   {62'd0, code0},      64'd2);
        chk("badck_cpurst", {63'd0, cpu_reset0}, 64'd1);
        chk("badck_done",   {63'd0, done0},      64'd0);

        // Stalled stream, reset after the 6th data byte (10th byte overall).
        wq0.delete(); wq1.delete();
        pulse_start();
        frame = '{8'h00, 8'h00, 8'h00, 8'h02,
                  8'h20, 8'h08, 8'h00, 8'h05,
                  8'h01, 8'h09, 8'h50, 8'h20, 8'h57};
        send_frame(10, 10);
        chk("stall_busy", {63'd0, busy0}, 64'd1);
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("stall_nwr", 64'(wq0.size()), 64'd1);
        chk("stall_wr0", (wq0.size() > 0) ? wq0[0] : 64'hx, 64'h00000000_20080005);
        check_reset_values("postrst");
        wq0.delete(); wq1.delete();
        pulse_start();
        send_frame(0, -1);
        @(negedge clk);
        chk("reload_nwr",  64'(wq0.size()), 64'd2);
        chk("reload_wr1",  (wq0.size() > 1) ? wq0[1] : 64'hx, 64'h00000004_01095020);
        chk("reload_done", {63'd0, done0}, 64'd1);

        // Restart with ADDR_BASE = 0x400 (dut1); start while busy is ignored.
        // One word DEADBEEF: checksum 01^DE^AD^BE^EF = 0x23.
        wq0.delete(); wq1.delete();
        pulse_start();
        chk("rs_cpurst_rise", {63'd0, cpu_reset1}, 64'd1);
        frame = '{8'h00, 8'h00, 8'h00, 8'h01,
                  8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
        send_frame(0, 6);
        pulse_start();
        chk("rs_busy_start_busy",  {63'd0, busy1},  64'd1);
        chk("rs_busy_start_ready", {63'd0, ready1}, 64'd1);
        send_byte(frame[6]);
        send_byte(frame[7]);
        send_byte(frame[8]);
        @(negedge clk);
        chk("rs1_nwr",  64'(wq1.size()), 64'd1);
        chk("rs1_wr1",  (wq1.size() > 0) ? wq1[0] : 64'hx, 64'h00000400_DEADBEEF);
        chk("rs1_wr0",  (wq0.size() > 0) ? wq0[0] : 64'hx, 64'h00000000_DEADBEEF);
        chk("rs1_done", {63'd0, done1}, 64'd1);
        chk("rs1_cpurst", {63'd0, cpu_reset1}, 64'd0);

        // Second session from DONE. Checksum 01^12^34^56^78 = 0x09.
        wq0.delete(); wq1.delete();
        pulse_start();
        chk("rs2_cpurst_rise", {63'd0, cpu_reset1}, 64'd1);
        chk("rs2_done_clr",    {63'd0, done1},      64'd0);
        frame = '{8'h00, 8'h00, 8'h00, 8'h01,
                  8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        send_frame(0, -1);
        @(negedge clk);
        chk("rs2_nwr",    64'(wq1.size()), 64'd1);
        chk("rs2_wr",     (wq1.size() > 0) ? wq1[0] : 64'hx, 64'h00000400_12345678);
        chk("rs2_done",   {63'd0, done1},      64'd1);
        chk("rs2_cpurst", {63'd0, cpu_reset1}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
